// File: rtl/pwm_capture_if.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_capture_if
//  Brief    : PWM pin input and measurement result bundle for pwm_capture.
//  Revision : 1.0 - initial release
// ============================================================================
interface pwm_capture_if #(
    parameter int WIDTH = 8
);
    logic             pwm_in;
    logic [WIDTH-1:0] high_time;
    logic [WIDTH-1:0] period;
    logic             meas_valid;
    logic             stuck;
    logic             level;

    // master = the capture block, slave = pin driver / result consumer
    modport master (
        input  pwm_in,
        output high_time,
        output period,
        output meas_valid,
        output stuck,
        output level
    );

    modport slave (
        output pwm_in,
        input  high_time,
        input  period,
        input  meas_valid,
        input  stuck,
        input  level
    );
endinterface
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_capture
//  Brief    : Measures high time and period of an asynchronous PWM input,
//             flags a stuck line when no rising edge arrives in time.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_capture #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    pwm_capture_if.master bus
);

    localparam logic [WIDTH-1:0] c_cnt_max = '1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MEAS = 1'b1
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic [WIDTH-1:0]       r_per_cnt;
    logic [WIDTH-1:0]       r_hi_cnt;
    logic [WIDTH-1:0]       r_high_time;
    logic [WIDTH-1:0]       r_period;
    logic                   r_meas_valid;
    logic                   r_stuck;

    logic                   w_s;
    logic                   w_rise;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_s_d;

    // A pin already high at reset release shows up as a rise and arms the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pwm_in};
            r_s_d  <= w_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_per_cnt    <= '0;
            r_hi_cnt     <= '0;
            r_high_time  <= '0;
            r_period     <= '0;
            r_meas_valid <= 1'b0;
            r_stuck      <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_per_cnt <= WIDTH'(1);
                        r_hi_cnt  <= WIDTH'(1);
                        r_state   <= ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    // A rise coinciding with the terminal count is still a valid period.
                    if (w_rise) begin
                        r_period     <= r_per_cnt;
                        r_high_time  <= r_hi_cnt;
                        r_stuck      <= 1'b0;
                        r_meas_valid <= 1'b1;
                        r_per_cnt    <= WIDTH'(1);
                        r_hi_cnt     <= WIDTH'(1);
                    end else if (r_per_cnt == c_cnt_max) begin
                        r_period     <= '0;
                        r_high_time  <= '0;
                        r_stuck      <= 1'b1;
                        r_meas_valid <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_per_cnt <= r_per_cnt + WIDTH'(1);
                        r_hi_cnt  <= r_hi_cnt + WIDTH'(w_s);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.high_time  = r_high_time;
    assign bus.period     = r_period;
    assign bus.meas_valid = r_meas_valid;
    assign bus.stuck      = r_stuck;
    assign bus.level      = w_s;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_capture
//  Brief    : Self-checking bench for pwm_capture against a timestamp model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;

    localparam int W    = 4;
    localparam int SYNC = 2;
    localparam int MAXC = (1 << W) - 1;
    localparam int HIST = 65536;

    logic clk;
    logic rst_n;

    pwm_capture_if #(.WIDTH(W)) bus ();

    pwm_capture #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: pin value seen at each clock edge, plus timestamps of accepted rises.
    bit         pin_at [0:HIST-1];
    int         k;
    int         vf;
    int         last_rise;
    bit         armed;
    bit         exp_valid;
    bit         exp_stuck;
    bit         exp_level;
    logic [W-1:0] exp_high;
    logic [W-1:0] exp_per;

    int checks;
    int passes;
    int nstrobe;

    function automatic bit samp(input int e);
        if (e < 0 || e < vf || e >= HIST) return 1'b0;
        return pin_at[e];
    endfunction

    initial begin
        k = 0; vf = 0; last_rise = 0; armed = 1'b0;
        exp_valid = 1'b0; exp_stuck = 1'b0; exp_level = 1'b0;
        exp_high = '0; exp_per = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (clk) begin
                k = k + 1;
                if (k < HIST) pin_at[k] = bus.pwm_in;
            end
            if (!rst_n) begin
                armed = 1'b0; vf = k + 1;
                exp_valid = 1'b0; exp_stuck = 1'b0; exp_level = 1'b0;
                exp_high = '0; exp_per = '0;
            end else if (clk) begin
                bit rise;
                int h;
                rise      = samp(k - SYNC) && !samp(k - SYNC - 1);
                exp_level = samp(k - SYNC + 1);
                exp_valid = 1'b0;
                if (armed) begin
                    if (rise) begin
                        h = 0;
                        for (int j = last_rise; j < k; j++) h += int'(samp(j - SYNC));
                        exp_per   = W'(k - last_rise);
                        exp_high  = W'(h);
                        exp_stuck = 1'b0;
                        exp_valid = 1'b1;
                        last_rise = k;
                    end else if (k - last_rise == MAXC) begin
                        exp_per   = '0;
                        exp_high  = '0;
                        exp_stuck = 1'b1;
                        exp_valid = 1'b1;
                        armed     = 1'b0;
                    end
                end else if (rise) begin
                    armed     = 1'b1;
                    last_rise = k;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        checks++;
        if (bus.meas_valid !== exp_valid || bus.high_time !== exp_high ||
            bus.period !== exp_per || bus.stuck !== exp_stuck || bus.level !== exp_level) begin
            $display("FAIL cycle_%0d: got v=%b hi=%0d per=%0d stuck=%b lvl=%b, expected v=%b hi=%0d per=%0d stuck=%b lvl=%b",
                     k, bus.meas_valid, bus.high_time, bus.period, bus.stuck, bus.level,
                     exp_valid, exp_high, exp_per, exp_stuck, exp_level);
        end else begin
            passes++;
        end
        if (bus.meas_valid === 1'b1) nstrobe++;
    endtask

    task automatic lit(input string name, input int act, input int req);
        checks++;
        if (act !== req) $display("FAIL %s: got %0d, expected %0d", name, act, req);
        else passes++;
    endtask

    task automatic drive(input bit v, input int n);
        bus.pwm_in = v;
        repeat (n) tick();
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        repeat (n) begin
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    initial begin
        int n0;
        int hi;
        int lo;
        checks = 0; passes = 0; nstrobe = 0;
        bus.pwm_in = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        lit("reset_period", int'(bus.period), 0);
        lit("reset_stuck", int'(bus.stuck), 0);
        rst_n = 1'b1;

        // Reset mid-measurement, during the low phase
        wave(3, 5, 2);
        drive(1'b1, 3);
        drive(1'b0, 2);
        rst_n = 1'b0;
        #1;
        lit("async_rst_high", int'(bus.high_time), 0);
        lit("async_rst_period", int'(bus.period), 0);
        lit("async_rst_valid", int'(bus.meas_valid), 0);
        tick(); tick();
        rst_n = 1'b1;
        drive(1'b0, 3);
        n0 = nstrobe;
        wave(3, 5, 3);
        lit("post_rst_strobes", nstrobe - n0, 2);
        lit("post_rst_high", int'(bus.high_time), 3);
        lit("post_rst_period", int'(bus.period), 8);

        // Steady wave
        n0 = nstrobe;
        wave(3, 5, 4);
        lit("steady_strobes", nstrobe - n0, 4);
        lit("steady_stuck", int'(bus.stuck), 0);

        // Duty step
        wave(6, 2, 3);
        lit("step_high", int'(bus.high_time), 6);
        lit("step_period", int'(bus.period), 8);

        // Minimum period
        wave(1, 1, 10);
        lit("min_high", int'(bus.high_time), 1);
        lit("min_period", int'(bus.period), 2);

        // Stuck high: the rise itself measures the prior period, then one timeout strobe
        drive(1'b0, 6);
        drive(1'b1, 4);
        n0 = nstrobe;
        drive(1'b1, 36);
        lit("stuck_strobes", nstrobe - n0, 1);
        lit("stuck_flag", int'(bus.stuck), 1);
        lit("stuck_level", int'(bus.level), 1);
        lit("stuck_period", int'(bus.period), 0);
        drive(1'b0, 4);
        n0 = nstrobe;
        wave(3, 5, 3);
        lit("rearm_strobes", nstrobe - n0, 2);
        lit("rearm_stuck", int'(bus.stuck), 0);
        lit("rearm_high", int'(bus.high_time), 3);

        // Boundary period: 15 measures, 16 times out
        wave(5, 10, 3);
        lit("max_period", int'(bus.period), 15);
        lit("max_stuck", int'(bus.stuck), 0);
        wave(5, 11, 3);
        lit("over_stuck", int'(bus.stuck), 1);
        lit("over_period", int'(bus.period), 0);
        wave(5, 10, 2);
        lit("recover_period", int'(bus.period), 15);
        lit("recover_stuck", int'(bus.stuck), 0);

        // Randomised waveforms, occasionally slow enough to time out
        for (int i = 0; i < 250; i++) begin
            hi = int'($urandom_range(1, 9));
            lo = int'($urandom_range(1, 9));
            if ($urandom_range(0, 15) == 0) lo = int'($urandom_range(12, 24));
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
        drive(1'b0, 20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
